// File: rtl/mc_controller.sv
// Control unit for the multicycle ARM datapath.
// Moore main FSM, combinational ALU decoder and conditional-execution logic with an
// internal NZCV flags register. All outputs are combinational from state, Instr and flags.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   Instr      instruction bits [31:12]: cond [19:16], op [15:14], funct [13:8], Rd [3:0]
//   ALUFlags   {N,Z,C,V} from the datapath ALU
//   PCWrite, MemWrite, RegWrite, IRWrite   write enables (forced 0 while reset is low)
//   AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl   datapath selects
module mc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb,
    StMemWr, StExecR, StExecI, StAluWb, StBranch
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;

  assign cond  = Instr[19:16];
  assign op    = Instr[15:14];
  assign funct = Instr[13:8];
  assign rd    = Instr[3:0];

  // ALU decoder; unknown commands fall back to ADD and block register and flag writes
  logic [1:0] alu_dec;
  logic       alu_valid;
  logic       alu_logic;

  always_comb begin
    alu_dec   = 2'b00;
    alu_valid = 1'b1;
    alu_logic = 1'b0;
    case (funct[4:1])
      4'b0100: alu_dec = 2'b00;
      4'b0010: alu_dec = 2'b01;
      4'b0000: begin alu_dec = 2'b10; alu_logic = 1'b1; end
      4'b1100: begin alu_dec = 2'b11; alu_logic = 1'b1; end
      default: alu_valid = 1'b0;
    endcase
  end

  // Condition check against the registered flags
  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_ex;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Flags update at the edge ending EXECR/EXECI; logical ops keep C and V
  always_comb begin
    flags_d = flags_q;
    if ((state_q == StExecR || state_q == StExecI) && funct[0] && cond_ex && alu_valid) begin
      if (alu_logic) flags_d[3:2] = ALUFlags[3:2];
      else           flags_d      = ALUFlags;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  logic pc_write, mem_write, reg_write, ir_write;

  always_comb begin
    state_d    = StFetch;
    pc_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    ir_write   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    unique case (state_q)
      StFetch: begin
        state_d   = StDecode;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      StDecode: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (op)
          2'b00:   state_d = funct[5] ? StExecI : StExecR;
          2'b01:   state_d = StMemAdr;
          2'b10:   state_d = StBranch;
          default: state_d = StFetch;
        endcase
      end
      StMemAdr: begin
        state_d    = funct[0] ? StMemRd : StMemWr;
        ALUSrcB    = 2'b01;
        ALUControl = funct[3] ? 2'b00 : 2'b01;  // U bit: add or subtract offset
      end
      StMemRd: begin
        state_d = StMemWb;
        AdrSrc  = 1'b1;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        reg_write = cond_ex;
        pc_write  = cond_ex & (rd == 4'b1111);
      end
      StMemWr: begin
        AdrSrc    = 1'b1;
        mem_write = cond_ex;
      end
      StExecR: begin
        state_d    = StAluWb;
        ALUControl = alu_dec;
      end
      StExecI: begin
        state_d    = StAluWb;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec;
      end
      StAluWb: begin
        reg_write = cond_ex & alu_valid;
        pc_write  = cond_ex & alu_valid & (rd == 4'b1111);
      end
      StBranch: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pc_write  = cond_ex;
      end
      default: state_d = StFetch;
    endcase
  end

  // Register-read and immediate decode depend only on op, in every state
  assign RegSrc = {op == 2'b01, op == 2'b10};
  assign ImmSrc = op;

  assign PCWrite  = pc_write & reset;
  assign MemWrite = mem_write & reset;
  assign RegWrite = reg_write & reset;
  assign IRWrite  = ir_write & reset;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: the stimulus process pushes the hand-computed
// expected outputs for each cycle; a monitor pops and compares on the falling edge.
module tb_mc_controller;

  logic        clk;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .RegSrc     (RegSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [16:0] outs;
    logic        chkf;
    logic [3:0]  fl;
    logic [7:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,RegSrc,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,ALUControl}
  function automatic logic [16:0] mk(input logic pcw, input logic mw, input logic rw,
                                     input logic irw, input logic adr, input logic [1:0] rsrc,
                                     input logic [1:0] asa, input logic [1:0] asb,
                                     input logic [1:0] res, input logic [1:0] imm,
                                     input logic [1:0] aluc);
    return {pcw, mw, rw, irw, adr, rsrc, asa, asb, res, imm, aluc};
  endfunction

  logic [7:0] tag_cnt = 0;

  task automatic step(input logic rst, input logic [19:0] ins, input logic [3:0] af,
                      input logic [16:0] outs, input logic chkf, input logic [3:0] fl);
    exp_t e;
    @(posedge clk);
    #1;
    reset    = rst;
    Instr    = ins;
    ALUFlags = af;
    e.outs = outs;
    e.chkf = chkf;
    e.fl   = fl;
    e.tag  = tag_cnt;
    tag_cnt = tag_cnt + 8'd1;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [16:0] act;
      e = sb.pop_front();
      act = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
             ResultSrc, ImmSrc, ALUControl};
      checks++;
      if (act !== e.outs) begin
        errors++;
        $display("FAIL outs cycle %0d: got %b want %b", e.tag, act, e.outs);
      end
      if (e.chkf) begin
        checks++;
        if (dut.flags_q !== e.fl) begin
          errors++;
          $display("FAIL flags cycle %0d: got %b want %b", e.tag, dut.flags_q, e.fl);
        end
      end
    end
  end

  // Instruction encodings, bits [31:12]: cond, op, funct, Rn, Rd
  localparam logic [19:0] AddsR = {4'b1110, 2'b00, 6'b001001, 4'h2, 4'h1};
  localparam logic [19:0] SubNe = {4'b0001, 2'b00, 6'b100100, 4'h1, 4'h1};
  localparam logic [19:0] Beq   = {4'b0000, 2'b10, 6'b100000, 4'h0, 4'h0};
  localparam logic [19:0] Ldr   = {4'b1110, 2'b01, 6'b010001, 4'h5, 4'h4};
  localparam logic [19:0] Str   = {4'b1110, 2'b01, 6'b011000, 4'h5, 4'h4};
  localparam logic [19:0] Op11  = {4'b1110, 2'b11, 6'b000000, 4'h0, 4'h0};
  localparam logic [19:0] AndsR = {4'b1110, 2'b00, 6'b000001, 4'h2, 4'h1};

  initial begin
    reset    = 1'b1;
    Instr    = '0;
    ALUFlags = '0;
    #1 reset = 1'b0;

    // Reset held for two cycles: enables low, selects at fetch values, flags cleared
    step(0, 20'h0, 4'h0, mk(0,0,0,0,0,2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 1, 4'b0000);
    step(0, 20'h0, 4'h0, mk(0,0,0,0,0,2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 1, 4'b0000);

    // ADDS R1,R2,R3 with ALUFlags 0110
    step(1, AddsR, 4'h0,    mk(1,0,0,1,0,2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 1, 4'b0000);
    step(1, AddsR, 4'h0,    mk(0,0,0,0,0,2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 0, 4'b0000);
    step(1, AddsR, 4'b0110, mk(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00), 1, 4'b0000);
    step(1, AddsR, 4'h0,    mk(0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00), 1, 4'b0110);

    // SUBNE R1,R1,#1 with Z=1: full length, no register write
    step(1, SubNe, 4'h0, mk(1,0,0,1,0,2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 0, 4'b0000);
    step(1, SubNe, 4'h0, mk(0,0,0,0,0,2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 0, 4'b0000);
    step(1, SubNe, 4'h0, mk(0,0,0,0,0,2'b00,2'b00,2'b01,2'b00,2'b00,2'b01), 0, 4'b0000);
    step(1, SubNe, 4'h0, mk(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00), 1, 4'b0110);

    // BEQ taken
    step(1, Beq, 4'h0, mk(1,0,0,1,0,2'b01,2'b01,2'b10,2'b10,2'b10,2'b00), 0, 4'b0000);
    step(1, Beq, 4'h0, mk(0,0,0,0,0,2'b01,2'b01,2'b10,2'b10,2'b10,2'b00), 0, 4'b0000);
    step(1, Beq, 4'h0, mk(1,0,0,0,0,2'b01,2'b00,2'b01,2'b10,2'b10,2'b00), 0, 4'b0000);

    // LDR R4,[R5,#-8]
    step(1, Ldr, 4'h0, mk(1,0,0,1,0,2'b10,2'b01,2'b10,2'b10,2'b01,2'b00), 0, 4'b0000);
    step(1, Ldr, 4'h0, mk(0,0,0,0,0,2'b10,2'b01,2'b10,2'b10,2'b01,2'b00), 0, 4'b0000);
    step(1, Ldr, 4'h0, mk(0,0,0,0,0,2'b10,2'b00,2'b01,2'b00,2'b01,2'b01), 0, 4'b0000);
    step(1, Ldr, 4'h0, mk(0,0,0,0,1,2'b10,2'b00,2'b00,2'b00,2'b01,2'b00), 0, 4'b0000);
    step(1, Ldr, 4'h0, mk(0,0,1,0,0,2'b10,2'b00,2'b00,2'b01,2'b01,2'b00), 0, 4'b0000);

    // STR R4,[R5,#+imm]
    step(1, Str, 4'h0, mk(1,0,0,1,0,2'b10,2'b01,2'b10,2'b10,2'b01,2'b00), 0, 4'b0000);
    step(1, Str, 4'h0, mk(0,0,0,0,0,2'b10,2'b01,2'b10,2'b10,2'b01,2'b00), 0, 4'b0000);
    step(1, Str, 4'h0, mk(0,0,0,0,0,2'b10,2'b00,2'b01,2'b00,2'b01,2'b00), 0, 4'b0000);
    step(1, Str, 4'h0, mk(0,1,0,0,1,2'b10,2'b00,2'b00,2'b00,2'b01,2'b00), 0, 4'b0000);

    // op=11: two cycles, no enables after fetch
    step(1, Op11, 4'h0, mk(1,0,0,1,0,2'b00,2'b01,2'b10,2'b10,2'b11,2'b00), 0, 4'b0000);
    step(1, Op11, 4'h0, mk(0,0,0,0,0,2'b00,2'b01,2'b10,2'b10,2'b11,2'b00), 0, 4'b0000);

    // ADDS loading flags 1111
    step(1, AddsR, 4'h0,    mk(1,0,0,1,0,2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 1, 4'b0110);
    step(1, AddsR, 4'h0,    mk(0,0,0,0,0,2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 0, 4'b0000);
    step(1, AddsR, 4'b1111, mk(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00), 0, 4'b0000);
    step(1, AddsR, 4'h0,    mk(0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00), 1, 4'b1111);

    // ANDS with ALUFlags 0100: C and V preserved -> 0111
    step(1, AndsR, 4'h0,    mk(1,0,0,1,0,2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 0, 4'b0000);
    step(1, AndsR, 4'h0,    mk(0,0,0,0,0,2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 0, 4'b0000);
    step(1, AndsR, 4'b0100, mk(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,2'b10), 1, 4'b1111);
    step(1, AndsR, 4'h0,    mk(0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00), 1, 4'b0111);

    // LDR aborted by reset in MEMRD
    step(1, Ldr, 4'h0, mk(1,0,0,1,0,2'b10,2'b01,2'b10,2'b10,2'b01,2'b00), 0, 4'b0000);
    step(1, Ldr, 4'h0, mk(0,0,0,0,0,2'b10,2'b01,2'b10,2'b10,2'b01,2'b00), 0, 4'b0000);
    step(1, Ldr, 4'h0, mk(0,0,0,0,0,2'b10,2'b00,2'b01,2'b00,2'b01,2'b01), 1, 4'b0111);
    step(0, Ldr, 4'h0, mk(0,0,0,0,0,2'b10,2'b01,2'b10,2'b10,2'b01,2'b00), 1, 4'b0000);
    step(0, Ldr, 4'h0, mk(0,0,0,0,0,2'b10,2'b01,2'b10,2'b10,2'b01,2'b00), 1, 4'b0000);
    step(1, AddsR, 4'h0, mk(1,0,0,1,0,2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 1, 4'b0000);
    step(1, AddsR, 4'h0, mk(0,0,0,0,0,2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 0, 4'b0000);

    // Let the monitor drain, bounded
    begin
      int waited;
      waited = 0;
      while (sb.size() > 0 && waited < 10) begin
        @(posedge clk);
        waited++;
      end
      if (sb.size() > 0) begin
        errors++;
        $display("FAIL drain: got %0d entries left want 0", sb.size());
      end
    end
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
